// File: rtl/mem_delay_ctrl.sv
// mem_delay_ctrl: sequences flush/fill/run for an external delay line.
// Tracks how many samples have been shifted in since the last clear and
// which delay-line slots hold valid data.
module mem_delay_ctrl #(
  parameter int DEL_LENGTH = 10,
  parameter int COUNT_SIZE = 4,
  parameter int FLUSH_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush_req,
  output logic                  flush_ack,
  output logic                  dl_aclr,
  output logic                  dl_clk_en,
  output logic                  out_valid,
  output logic [COUNT_SIZE-1:0] fill_cnt,
  output logic                  primed
);

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_FILL, S_RUN} state_t;

  localparam logic [COUNT_SIZE-1:0] DL_FULL = COUNT_SIZE'(DEL_LENGTH);
  localparam logic [COUNT_SIZE-1:0] DL_LAST = COUNT_SIZE'(DEL_LENGTH - 1);
  localparam logic [3:0]            FC_INIT = 4'(FLUSH_CYC - 1);

  state_t                state, state_nxt;
  logic [3:0]            fcnt;
  logic [DEL_LENGTH-1:0] vld_pipe;
  logic                  ack_q;
  logic                  flush_go;
  logic                  flush_done;

  // Handshake is purely combinational so data shifts on the accepting edge;
  // a pending flush blocks acceptance of the same-cycle sample.
  always_comb begin
    in_ready   = (state != S_FLUSH) & ~flush_req;
    dl_clk_en  = in_valid & in_ready;
    dl_aclr    = (state == S_FLUSH);
    flush_go   = (state != S_FLUSH) & flush_req;
    flush_done = (state == S_FLUSH) & (fcnt == 4'd0);
  end

  assign flush_ack = ack_q;
  assign out_valid = vld_pipe[DEL_LENGTH-1];
  assign primed    = (fill_cnt == DL_FULL);

  // Next-state decode; flush wins over everything outside FLUSH.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FLUSH: if (fcnt == 4'd0) state_nxt = S_IDLE;
      S_IDLE: begin
        if (flush_req)      state_nxt = S_FLUSH;
        else if (dl_clk_en) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (flush_req)                                state_nxt = S_FLUSH;
        else if (dl_clk_en && fill_cnt == DL_LAST)    state_nxt = S_RUN;
      end
      S_RUN:   if (flush_req) state_nxt = S_FLUSH;
      default: state_nxt = S_FLUSH;
    endcase
  end

  // State register; reset parks in FLUSH so power-up always clears the line.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state <= S_FLUSH;
    else         state <= state_nxt;
  end

  // Flush length counter: preloaded on entry, counts down while in FLUSH.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)                fcnt <= FC_INIT;
    else if (flush_go)          fcnt <= FC_INIT;
    else if (state == S_FLUSH && fcnt != 4'd0) fcnt <= fcnt - 4'd1;
  end

  // One-cycle ack in the first IDLE cycle after the flush ends.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) ack_q <= 1'b0;
    else         ack_q <= flush_done;
  end

  // Saturating shift counter, cleared on flush entry.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)                            fill_cnt <= '0;
    else if (flush_go)                      fill_cnt <= '0;
    else if (dl_clk_en && fill_cnt != DL_FULL) fill_cnt <= fill_cnt + 1'b1;
  end

  // Valid shadow of the delay line; zeroed on the edge the clear starts.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)        vld_pipe <= '0;
    else if (flush_go)  vld_pipe <= '0;
    else if (dl_clk_en) vld_pipe <= {vld_pipe[DEL_LENGTH-2:0], 1'b1};
  end

endmodule

// File: tb/tb_mem_delay_ctrl.sv
// Directed bench for mem_delay_ctrl (DEL_LENGTH=10, FLUSH_CYC=2).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_mem_delay_ctrl;
  localparam int CS = 4;

  logic          clk = 1'b0;
  logic          aclr_n;
  logic          in_valid, flush_req;
  logic          in_ready, flush_ack, dl_aclr, dl_clk_en, out_valid, primed;
  logic [CS-1:0] fill_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_delay_ctrl #(.DEL_LENGTH(10), .COUNT_SIZE(CS), .FLUSH_CYC(2)) dut (
    .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready),
    .flush_req(flush_req), .flush_ack(flush_ack), .dl_aclr(dl_aclr),
    .dl_clk_en(dl_clk_en), .out_valid(out_valid), .fill_cnt(fill_cnt),
    .primed(primed)
  );

  task automatic drive(input logic iv, input logic fr);
    @(negedge clk);
    in_valid  = iv;
    flush_req = fr;
    #1;
  endtask

  // Expected order: in_ready, dl_clk_en, dl_aclr, flush_ack, out_valid, primed, fill_cnt
  task automatic chk(input string tag, input logic ir, input logic ce,
                     input logic ac, input logic fa, input logic ov,
                     input logic pr, input int fc);
    logic [CS+5:0] obs, exp;
    obs = {in_ready, dl_clk_en, dl_aclr, flush_ack, out_valid, primed, fill_cnt};
    exp = {ir, ce, ac, fa, ov, pr, CS'(fc)};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b (ir,ce,ac,fa,ov,pr,cnt)", tag, obs, exp);
    end
  endtask

  initial begin
    aclr_n = 1'b0; in_valid = 1'b1; flush_req = 1'b0;
    #3;
    chk("reset_hold", 0, 0, 1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_hold2", 0, 0, 1, 0, 0, 0, 0);

    // Reset release: two clear cycles, then the ack in IDLE.
    @(negedge clk); aclr_n = 1'b1; in_valid = 1'b0; #1;
    chk("rel_flush1", 0, 0, 1, 0, 0, 0, 0);
    drive(1, 0); chk("rel_flush2_iv", 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0); chk("rel_ack", 1, 0, 0, 1, 0, 0, 0);
    drive(0, 0); chk("rel_idle", 1, 0, 0, 0, 0, 0, 0);

    // Continuous fill of 12 samples; count saturates at 10.
    for (int i = 0; i < 12; i++) begin
      drive(1, 0);
      chk($sformatf("fill_%0d", i), 1, 1, 0, 0, (i >= 10), (i >= 10), (i >= 10) ? 10 : i);
    end
    drive(0, 0); chk("fill_done", 1, 0, 0, 0, 1, 1, 10);

    // Flush in RUN with a simultaneous sample: sample refused.
    drive(1, 1); chk("run_flush_req", 0, 0, 0, 0, 1, 1, 10);
    drive(1, 0); chk("run_flush1", 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0); chk("run_flush2", 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0); chk("run_ack", 1, 0, 0, 1, 0, 0, 0);
    drive(0, 0); chk("run_after", 1, 0, 0, 0, 0, 0, 0);

    // Stalled fill: 5 accepts, 4 stalls, 5 accepts.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0); chk($sformatf("stfill_a%0d", i), 1, 1, 0, 0, 0, 0, i);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0); chk($sformatf("stall_%0d", i), 1, 0, 0, 0, 0, 0, 5);
    end
    for (int i = 5; i < 10; i++) begin
      drive(1, 0); chk($sformatf("stfill_b%0d", i), 1, 1, 0, 0, 0, 0, i);
    end
    drive(0, 0); chk("stfill_full", 1, 0, 0, 0, 1, 1, 10);

    // flush_req held high: one complete flush, ack, then a second flush.
    drive(0, 1); chk("hold_req", 0, 0, 0, 0, 1, 1, 10);
    drive(0, 1); chk("hold_flush1", 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1); chk("hold_flush2", 0, 0, 1, 0, 0, 0, 0);
    drive(0, 1); chk("hold_ack", 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0); chk("hold_reflush1", 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0); chk("hold_reflush2", 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0); chk("hold_reack", 1, 0, 0, 1, 0, 0, 0);
    drive(0, 0); chk("hold_idle", 1, 0, 0, 0, 0, 0, 0);

    // Async reset during FILL at fill_cnt=6.
    for (int i = 0; i < 6; i++) drive(1, 0);
    drive(0, 0); chk("mid_cnt6", 1, 0, 0, 0, 0, 0, 6);
    @(negedge clk); #2; aclr_n = 1'b0; in_valid = 1'b1; #1;
    chk("mid_reset", 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk); aclr_n = 1'b1; #1;
    chk("mid_flush1", 0, 0, 1, 0, 0, 0, 0);
    drive(1, 0); chk("mid_flush2", 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0); chk("mid_ack", 1, 0, 0, 1, 0, 0, 0);
    drive(1, 0); chk("mid_accept", 1, 1, 0, 0, 0, 0, 0);
    drive(0, 0); chk("mid_cnt1", 1, 0, 0, 0, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_delay_ctrl.md
MEM_DELAY_CTRL -- requirements
Module: mem_delay_ctrl

Interface
REQ-001 SHALL have parameter DEL_LENGTH, default 10: delay-line depth in enabled shifts; legal range 2..(2**COUNT_SIZE - 1).
REQ-002 SHALL have parameter COUNT_SIZE, default 4: width of fill_cnt.
REQ-003 SHALL have parameter FLUSH_CYC, default 2: number of cycles dl_aclr is held high per flush; legal range 1..15.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port aclr_n, input, 1: reset; asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1: upstream sample present this cycle.
REQ-007 SHALL have port in_ready, output, 1: controller accepts a sample this cycle.
REQ-008 SHALL have port flush_req, input, 1: request to clear the delay line; level-sampled each cycle.
REQ-009 SHALL have port flush_ack, output, 1: one-cycle pulse when a flush completes.
REQ-010 SHALL have port dl_aclr, output, 1: active-high clear to the delay line.
REQ-011 SHALL have port dl_clk_en, output, 1: shift enable to the delay line.
REQ-012 SHALL have port out_valid, output, 1: delay-line output currently holds a valid sample.
REQ-013 SHALL have port fill_cnt, output, COUNT_SIZE: enabled shifts since the last flush, saturating.
REQ-014 SHALL have port primed, output, 1: the delay line is full (fill_cnt == DEL_LENGTH).

Function
REQ-015 SHALL implement a four-state FSM: FLUSH, IDLE, FILL and RUN.
REQ-016 SHALL drive in_ready combinationally as (state != FLUSH) & ~flush_req.
REQ-017 SHALL drive dl_clk_en combinationally as in_valid & in_ready, with zero latency, so data shifts on the same edge that it is accepted.
REQ-018 SHALL drive dl_aclr high during reset and for every cycle in FLUSH, and low otherwise.
REQ-019 SHALL, in FLUSH, load a down-counter with FLUSH_CYC-1 on entry, decrement it each cycle, and go to IDLE when it reaches 0, so FLUSH lasts exactly FLUSH_CYC cycles.
REQ-020 SHALL pulse flush_ack high for exactly one cycle: the first cycle in IDLE after FLUSH exits.
REQ-021 SHALL transition IDLE -> FILL on the first dl_clk_en.
REQ-022 SHALL transition FILL -> RUN on the edge where fill_cnt becomes DEL_LENGTH.
REQ-023 SHALL remain in RUN until a flush occurs.
REQ-024 SHALL go to FLUSH from any non-FLUSH state when flush_req=1; flush takes priority over a simultaneous in_valid, and that sample is not accepted.
REQ-025 SHALL ignore flush_req while in FLUSH; the flush sequence is not restarted or extended.
REQ-026 SHALL increment fill_cnt by 1 on each dl_clk_en, saturate it at DEL_LENGTH with no wrap, and clear it to 0 on FLUSH entry.
REQ-027 SHALL drive primed = (fill_cnt == DEL_LENGTH) as a registered-state decode.
REQ-028 SHALL maintain a DEL_LENGTH-bit valid shadow register that shifts in 1 on each dl_clk_en and holds when dl_clk_en=0.
REQ-029 SHALL drive out_valid from the last bit of the shadow register, so that it rises on the DEL_LENGTH-th accepted sample after a flush.
REQ-030 SHALL zero the shadow register on FLUSH entry, so that out_valid falls on the same edge dl_aclr rises.
REQ-031 SHALL hold fill_cnt, the shadow register and state unchanged on stall cycles (in_valid=0 outside FLUSH).

Reset
REQ-032 SHALL, while aclr_n=0, hold state=FLUSH with the flush counter at FLUSH_CYC-1, fill_cnt=0, shadow=0, out_valid=0, primed=0, flush_ack=0, dl_aclr=1, in_ready=0 and dl_clk_en=0.
REQ-033 SHALL, after aclr_n rises, complete a normal FLUSH_CYC-cycle flush, so the delay line is always cleared after power-up.
REQ-034 SHALL abandon any operation in progress on an aclr_n assertion mid-operation and force all outputs to their reset values asynchronously.

Verification (DEL_LENGTH=10, FLUSH_CYC=2)
REQ-035 SHALL cover reset release: dl_aclr stays high 2 cycles, then flush_ack pulses 1 cycle with in_ready=1 and state IDLE.
REQ-036 SHALL cover a continuous fill: in_valid=1 for 12 cycles -> fill_cnt 1..10 then holds at 10, primed and out_valid rise after the 10th accept, and dl_clk_en=1 on all 12 cycles.
REQ-037 SHALL cover a stalled fill: 5 accepts, 4 idle cycles, 5 accepts -> fill_cnt holds at 5 during the stall and out_valid rises only after the 10th accept.
REQ-038 SHALL cover flush in RUN with in_valid=1 in the same cycle: in_ready=0 and dl_clk_en=0 that cycle, next edge fill_cnt=0 and out_valid=0, dl_aclr high 2 cycles, then flush_ack pulses.
REQ-039 SHALL cover flush_req held high through FLUSH: exactly 2 dl_aclr cycles and one flush_ack, after which a new flush starts if flush_req is still 1.
REQ-040 SHALL cover aclr_n pulsed low during FILL at fill_cnt=6: outputs reset immediately, and the post-reset flush completes with fill_cnt=0.
